// File: rtl/bti_arb2.sv
// Two-master to one-slave BTI arbiter: round-robin request grant with a
// grant-ID FIFO that steers in-order slave responses back to their issuer.
module bti_arb2 #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int OST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req_vld,
  output logic            m0_req_rdy,
  input  logic [AW-1:0]   m0_req_addr,
  input  logic            m0_req_cmd,
  input  logic [DW-1:0]   m0_req_wdata,
  input  logic [DW/8-1:0] m0_req_wstrb,
  output logic            m0_rsp_vld,
  input  logic            m0_rsp_rdy,
  output logic [DW-1:0]   m0_rsp_rdata,
  input  logic            m1_req_vld,
  output logic            m1_req_rdy,
  input  logic [AW-1:0]   m1_req_addr,
  input  logic            m1_req_cmd,
  input  logic [DW-1:0]   m1_req_wdata,
  input  logic [DW/8-1:0] m1_req_wstrb,
  output logic            m1_rsp_vld,
  input  logic            m1_rsp_rdy,
  output logic [DW-1:0]   m1_rsp_rdata,
  output logic            s_req_vld,
  input  logic            s_req_rdy,
  output logic [AW-1:0]   s_req_addr,
  output logic            s_req_cmd,
  output logic [DW-1:0]   s_req_wdata,
  output logic [DW/8-1:0] s_req_wstrb,
  input  logic            s_rsp_vld,
  output logic            s_rsp_rdy,
  input  logic [DW-1:0]   s_rsp_rdata,
  output logic            err
);

  localparam int PW = $clog2(OST);
  localparam int CW = PW + 1;

  logic           rr;
  logic           lock;
  logic           gid_lat;
  logic           gid;
  logic [OST-1:0] fifo;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  cnt;
  logic           not_full;
  logic           not_empty;
  logic           head;
  logic           push;
  logic           pop;
  logic           drop;
  logic           req_ok;
  logic           rsp_live;

  always_comb begin
    not_full  = (cnt != CW'(OST));
    not_empty = (cnt != '0);

    // A stalled slave request keeps its grant so the payload cannot switch under it
    if (lock)                          gid = gid_lat;
    else if (m0_req_vld && !m1_req_vld) gid = 1'b0;
    else if (m1_req_vld && !m0_req_vld) gid = 1'b1;
    else                               gid = rr;

    s_req_addr  = gid ? m1_req_addr  : m0_req_addr;
    s_req_cmd   = gid ? m1_req_cmd   : m0_req_cmd;
    s_req_wdata = gid ? m1_req_wdata : m0_req_wdata;
    s_req_wstrb = gid ? m1_req_wstrb : m0_req_wstrb;

    s_req_vld  = !rst && not_full && (gid ? m1_req_vld : m0_req_vld);
    req_ok     = !rst && not_full && s_req_rdy;
    m0_req_rdy = req_ok && !gid;
    m1_req_rdy = req_ok && gid;
    push       = s_req_vld && s_req_rdy;

    head         = fifo[rd_ptr];
    rsp_live     = !rst && s_rsp_vld && not_empty;
    m0_rsp_vld   = rsp_live && !head;
    m1_rsp_vld   = rsp_live && head;
    m0_rsp_rdata = head ? '0 : s_rsp_rdata;
    m1_rsp_rdata = head ? s_rsp_rdata : '0;

    // With nothing outstanding a stray response is swallowed so the slave never hangs
    if (rst)            s_rsp_rdy = 1'b0;
    else if (not_empty) s_rsp_rdy = head ? m1_rsp_rdy : m0_rsp_rdy;
    else                s_rsp_rdy = s_rsp_vld;

    pop  = s_rsp_vld && s_rsp_rdy && not_empty;
    drop = !rst && s_rsp_vld && !not_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr      <= 1'b0;
      lock    <= 1'b0;
      gid_lat <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        rr     <= ~gid;
        lock   <= 1'b0;
      end else if (s_req_vld) begin
        lock    <= 1'b1;
        gid_lat <= gid;
      end
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (drop) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= gid;
  end

endmodule

// File: tb/tb_bti_arb2.sv
// Directed bench for bti_arb2: inputs change after the falling edge, outputs
// are checked 1ns later, and the rising edge commits the cycle.
module tb_bti_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_vld, m0_req_rdy, m0_req_cmd, m0_rsp_vld, m0_rsp_rdy;
  logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
  logic [3:0]  m0_req_wstrb;
  logic        m1_req_vld, m1_req_rdy, m1_req_cmd, m1_rsp_vld, m1_rsp_rdy;
  logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
  logic [3:0]  m1_req_wstrb;
  logic        s_req_vld, s_req_rdy, s_req_cmd, s_rsp_vld, s_rsp_rdy, err;
  logic [31:0] s_req_addr, s_req_wdata, s_rsp_rdata;
  logic [3:0]  s_req_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bti_arb2 #(.AW(32), .DW(32), .OST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req_vld(m0_req_vld), .m0_req_rdy(m0_req_rdy), .m0_req_addr(m0_req_addr),
    .m0_req_cmd(m0_req_cmd), .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
    .m0_rsp_vld(m0_rsp_vld), .m0_rsp_rdy(m0_rsp_rdy), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_vld(m1_req_vld), .m1_req_rdy(m1_req_rdy), .m1_req_addr(m1_req_addr),
    .m1_req_cmd(m1_req_cmd), .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
    .m1_rsp_vld(m1_rsp_vld), .m1_rsp_rdy(m1_rsp_rdy), .m1_rsp_rdata(m1_rsp_rdata),
    .s_req_vld(s_req_vld), .s_req_rdy(s_req_rdy), .s_req_addr(s_req_addr),
    .s_req_cmd(s_req_cmd), .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb),
    .s_rsp_vld(s_rsp_vld), .s_rsp_rdy(s_rsp_rdy), .s_rsp_rdata(s_rsp_rdata),
    .err(err)
  );

  task automatic idle();
    m0_req_vld = 0; m0_req_addr = '0; m0_req_cmd = 0; m0_req_wdata = '0; m0_req_wstrb = '0;
    m1_req_vld = 0; m1_req_addr = '0; m1_req_cmd = 0; m1_req_wdata = '0; m1_req_wstrb = '0;
    m0_rsp_rdy = 0; m1_rsp_rdy = 0;
    s_req_rdy = 0; s_rsp_vld = 0; s_rsp_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle();
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    idle();
    #1;
    n_checks++;
    if ({s_req_vld, m0_req_rdy, m1_req_rdy, m0_rsp_vld, m1_rsp_vld, s_rsp_rdy} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs_in_rst: got %b want 000000",
        {s_req_vld, m0_req_rdy, m1_req_rdy, m0_rsp_vld, m1_rsp_vld, s_rsp_rdy});
    end
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({s_req_vld, m0_req_rdy, m1_req_rdy, m0_rsp_vld, m1_rsp_vld, s_rsp_rdy, err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs_after: got %b want 0000000",
        {s_req_vld, m0_req_rdy, m1_req_rdy, m0_rsp_vld, m1_rsp_vld, s_rsp_rdy, err});
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    idle();
    m0_req_vld = 1; m0_req_addr = 32'h100; s_req_rdy = 1;
    #1;
    n_checks++;
    if (s_req_vld !== 1'b1 || s_req_addr !== 32'h100 || s_req_cmd !== 1'b0) begin
      n_fail++; $display("FAIL single_req: got vld=%b addr=%h cmd=%b want 1 00000100 0",
        s_req_vld, s_req_addr, s_req_cmd);
    end
    n_checks++;
    if (m0_req_rdy !== 1'b1 || m1_req_rdy !== 1'b0) begin
      n_fail++; $display("FAIL single_rdy: got m0=%b m1=%b want 1 0", m0_req_rdy, m1_req_rdy);
    end
    @(negedge clk);
    idle();
    s_rsp_vld = 1; s_rsp_rdata = 32'hDEADBEEF; m0_rsp_rdy = 1; m1_rsp_rdy = 1;
    #1;
    n_checks++;
    if (m0_rsp_vld !== 1'b1 || m0_rsp_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_rsp: got vld=%b data=%h want 1 deadbeef", m0_rsp_vld, m0_rsp_rdata);
    end
    n_checks++;
    if (m1_rsp_vld !== 1'b0 || m1_rsp_rdata !== 32'h0 || s_rsp_rdy !== 1'b1) begin
      n_fail++; $display("FAIL single_other: got m1vld=%b m1data=%h srdy=%b want 0 0 1",
        m1_rsp_vld, m1_rsp_rdata, s_rsp_rdy);
    end
  endtask

  task automatic test_round_robin();
    int i0 = 0;
    int i1 = 0;
    int exp_m;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      m0_req_vld = (i0 < 4); m0_req_addr = 32'h1000 + 32'(i0 * 4);
      m1_req_vld = (i1 < 4); m1_req_addr = 32'h2000 + 32'(i1 * 4);
      s_req_rdy = 1; m0_rsp_rdy = 1; m1_rsp_rdy = 1;
      s_rsp_vld = (k >= 1);
      s_rsp_rdata = 32'hA000_0000 + 32'(k);
      #1;
      if (k < 8) begin
        exp_m = k % 2;
        exp_addr = (exp_m == 0) ? 32'h1000 + 32'(i0 * 4) : 32'h2000 + 32'(i1 * 4);
        n_checks++;
        if (s_req_vld !== 1'b1 || s_req_addr !== exp_addr) begin
          n_fail++; $display("FAIL rr_grant k=%0d: got vld=%b addr=%h want 1 %h", k, s_req_vld, s_req_addr, exp_addr);
        end
        if (exp_m == 0) i0++; else i1++;
      end
      if (k >= 1) begin
        exp_data = 32'hA000_0000 + 32'(k);
        n_checks++;
        if ((k % 2) == 1) begin
          if (m0_rsp_vld !== 1'b1 || m1_rsp_vld !== 1'b0 || m0_rsp_rdata !== exp_data) begin
            n_fail++; $display("FAIL rr_rsp k=%0d: got m0vld=%b m1vld=%b data=%h want 1 0 %h",
              k, m0_rsp_vld, m1_rsp_vld, m0_rsp_rdata, exp_data);
          end
        end else begin
          if (m1_rsp_vld !== 1'b1 || m0_rsp_vld !== 1'b0 || m1_rsp_rdata !== exp_data) begin
            n_fail++; $display("FAIL rr_rsp k=%0d: got m1vld=%b m0vld=%b data=%h want 1 0 %h",
              k, m1_rsp_vld, m0_rsp_vld, m1_rsp_rdata, exp_data);
          end
        end
      end
    end
  endtask

  task automatic test_grant_hold();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      m1_req_vld = (c < 4); m1_req_addr = 32'h300;
      m0_req_vld = (c >= 1); m0_req_addr = 32'h200;
      s_req_rdy = (c >= 3);
      #1;
      n_checks++;
      if (c < 4) begin
        if (s_req_vld !== 1'b1 || s_req_addr !== 32'h300 || m1_req_rdy !== (c == 3) || m0_req_rdy !== 1'b0) begin
          n_fail++; $display("FAIL hold c=%0d: got vld=%b addr=%h m1rdy=%b m0rdy=%b want 1 00000300 %b 0",
            c, s_req_vld, s_req_addr, m1_req_rdy, m0_req_rdy, (c == 3));
        end
      end else begin
        if (s_req_addr !== 32'h200 || m0_req_rdy !== 1'b1) begin
          n_fail++; $display("FAIL hold_after: got addr=%h m0rdy=%b want 00000200 1", s_req_addr, m0_req_rdy);
        end
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      m0_req_vld = 1; m0_req_addr = 32'h500 + 32'(c); s_req_rdy = 1;
      s_rsp_vld = (c == 6); s_rsp_rdata = 32'h44; m0_rsp_rdy = 1;
      #1;
      n_checks++;
      if (m0_req_rdy !== (c < 4 || c == 7) || s_req_vld !== (c < 4 || c == 7)) begin
        n_fail++; $display("FAIL full c=%0d: got rdy=%b svld=%b want %b", c, m0_req_rdy, s_req_vld, (c < 4 || c == 7));
      end
      if (c == 6) begin
        n_checks++;
        if (m0_rsp_vld !== 1'b1 || m0_rsp_rdata !== 32'h44) begin
          n_fail++; $display("FAIL full_rsp: got vld=%b data=%h want 1 00000044", m0_rsp_vld, m0_rsp_rdata);
        end
      end
    end
  endtask

  task automatic test_write_read();
    do_reset();
    @(negedge clk);
    m0_req_vld = 1; m0_req_cmd = 1; m0_req_addr = 32'h8; m0_req_wdata = 32'hAA55; m0_req_wstrb = 4'hF;
    m1_req_vld = 1; m1_req_cmd = 0; m1_req_addr = 32'h8;
    s_req_rdy = 1;
    #1;
    n_checks++;
    if (s_req_cmd !== 1'b1 || s_req_addr !== 32'h8 || s_req_wdata !== 32'hAA55 || s_req_wstrb !== 4'hF || m0_req_rdy !== 1'b1) begin
      n_fail++; $display("FAIL wr_req: got cmd=%b addr=%h wd=%h ws=%h rdy=%b want 1 8 aa55 f 1",
        s_req_cmd, s_req_addr, s_req_wdata, s_req_wstrb, m0_req_rdy);
    end
    @(negedge clk);
    m0_req_vld = 0; m0_req_cmd = 0;
    s_rsp_vld = 1; s_rsp_rdata = 32'h0; m0_rsp_rdy = 1;
    #1;
    n_checks++;
    if (s_req_cmd !== 1'b0 || s_req_addr !== 32'h8 || m1_req_rdy !== 1'b1 || m0_rsp_vld !== 1'b1 || m0_rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rd_req: got cmd=%b addr=%h m1rdy=%b m0rspvld=%b data=%h want 0 8 1 1 0",
        s_req_cmd, s_req_addr, m1_req_rdy, m0_rsp_vld, m0_rsp_rdata);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      m1_req_vld = 0; m0_rsp_rdy = 1;
      s_rsp_vld = 1; s_rsp_rdata = 32'hAA55; m1_rsp_rdy = (c == 2);
      #1;
      n_checks++;
      if (m1_rsp_vld !== 1'b1 || m1_rsp_rdata !== 32'hAA55 || s_rsp_rdy !== (c == 2) || m0_rsp_vld !== 1'b0) begin
        n_fail++; $display("FAIL rd_rsp c=%0d: got vld=%b data=%h srdy=%b m0vld=%b want 1 aa55 %b 0",
          c, m1_rsp_vld, m1_rsp_rdata, s_rsp_rdy, m0_rsp_vld, (c == 2));
      end
    end
  endtask

  task automatic test_err_reset();
    do_reset();
    @(negedge clk);
    s_rsp_vld = 1; s_rsp_rdata = 32'h55; m0_rsp_rdy = 1; m1_rsp_rdy = 1;
    #1;
    n_checks++;
    if (s_rsp_rdy !== 1'b1 || m0_rsp_vld !== 1'b0 || m1_rsp_vld !== 1'b0) begin
      n_fail++; $display("FAIL drop: got srdy=%b m0vld=%b m1vld=%b want 1 0 0", s_rsp_rdy, m0_rsp_vld, m1_rsp_vld);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL err_set: got %b want 1", err);
    end
    // two requests left outstanding, then reset arrives with m0 still requesting
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      m0_req_vld = 1; m0_req_addr = 32'h10; s_req_rdy = 1;
      rst = (c == 2);
    end
    #1;
    n_checks++;
    if (m0_req_rdy !== 1'b0 || s_req_vld !== 1'b0) begin
      n_fail++; $display("FAIL rst_quiet: got rdy=%b svld=%b want 0 0", m0_req_rdy, s_req_vld);
    end
    @(negedge clk);
    rst = 0;
    m0_req_vld = 1; m0_req_addr = 32'h40; m1_req_vld = 1; m1_req_addr = 32'h80; s_req_rdy = 0;
    #1;
    n_checks++;
    if (err !== 1'b0 || s_req_vld !== 1'b1 || s_req_addr !== 32'h40) begin
      n_fail++; $display("FAIL post_rst: got err=%b svld=%b addr=%h want 0 1 00000040", err, s_req_vld, s_req_addr);
    end
    @(negedge clk);
    s_rsp_vld = 1; s_rsp_rdata = 32'h77; m0_rsp_rdy = 1; m1_rsp_rdy = 1;
    #1;
    n_checks++;
    if (m0_rsp_vld !== 1'b0 || m1_rsp_vld !== 1'b0 || s_rsp_rdy !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_empty: got m0vld=%b m1vld=%b srdy=%b want 0 0 1", m0_rsp_vld, m1_rsp_vld, s_rsp_rdy);
    end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_single_read();
    test_round_robin();
    test_grant_hold();
    test_full();
    test_write_read();
    test_err_reset();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
